spi_flash_program_engine: RTL and testbench
===========================================

# spi_flash_program_engine

SPI master that writes to the ROM flash on behalf of the 6809: a single-byte page program or a 4 KB sector erase, each followed by status polling until the operation completes. It is the write-side counterpart to the flash read controller and shares the same flash pins through the top-level SPI multiplexer. The block sits behind a bus-register front end that supplies the address and data and pulses start. It reports busy, done and error back to that front end.

## Interface
- CS_GAP, 4: clk cycles CS is held high between transactions (min 1)
- POLL_LIMIT, 65535: max status-poll transactions before timeout error (16-bit counter)
- clk  in  1  internal oscillator clock
- reset  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle request pulse; ignored while o_busy=1
- i_erase  in  1  sampled with i_start: 1 = sector erase (0x20), 0 = page program (0x02)
- i_addr  in  24  flash byte address, sampled with i_start
- i_data  in  8  program byte, sampled with i_start (unused for erase)
- o_busy  out  1  high from the cycle after an accepted i_start until o_done
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  poll timeout flag; valid with o_done; held until the next accepted start
- o_status  out  8  last status byte read from flash
- o_SPI_CLK  out  1  SPI clock, mode 0
- o_SPI_MOSI  out  1  SPI data out, MSB first
- o_SPI_CS  out  1  flash chip select, active low
- i_SPI_MISO  in  1  SPI data in

## Operation
- Reset values: o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0, o_busy=0, o_done=0, o_error=0, o_status=0x00, state IDLE.
- State sequence: IDLE -> WREN -> GAP1 -> CMD -> GAP2 -> POLL -> (GAP3 -> POLL)* -> DONE -> IDLE.
- IDLE: on i_start, latch i_erase, i_addr, i_data; clear o_error and the poll counter; enter WREN.
- WREN: send byte 0x06, then raise CS.
- GAP1 and GAP2: hold CS high for CS_GAP cycles.
- CMD, program: send 0x02, addr[23:16], addr[15:8], addr[7:0], data (5 bytes).
- CMD, erase: send 0x20 and the 3 address bytes (4 bytes).
- POLL: send 0x05, then clock in 1 byte with MOSI=0; o_status is loaded with that byte when CS rises.
  - If status bit0 (WIP) = 0, go to DONE.
  - Else, if the poll count is below POLL_LIMIT, increment it and go to GAP3, then back to POLL.
  - Else set o_error=1 and go to DONE.
- DONE: o_done=1 for one cycle, o_busy falls in the same cycle, then IDLE.
- Each CS-low transaction is one CS-asserted envelope. Multi-byte transfers have no gaps between bytes.
- Asynchronous reset mid-transaction aborts immediately to reset values. No partial command is retried.
- The 6809 and top level must not issue flash reads while o_busy=1. This block performs no arbitration.

## Timing
- SCK = clk/2. Bit k of a transaction occupies 2 clk cycles:
  - Phase A: SCK=0, MOSI driven with the bit.
  - Phase B: SCK=1. MISO is sampled on the clk edge that ends phase B.
- Transaction envelope: CS falls 1 cycle before the first phase A. CS rises 1 cycle after the last phase B. SCK is low whenever CS is high.
- Transaction length in CS-low cycles: 16×bytes + 2.
  - WREN = 18.
  - Program = 82.
  - Erase = 66.
  - Poll = 34.
- Latency from i_start to o_busy rising: 1 cycle.
- Program with WIP clear on the first poll, i_start to o_done: 1 + 18 + CS_GAP + 82 + CS_GAP + 34 + 1 = 144 cycles at CS_GAP=4.
- Each additional poll adds CS_GAP + 34 cycles.
- i_start asserted in the same cycle as o_done is ignored. A start is accepted only in IDLE.

## Test plan
- Program, addr=0x00F123, data=0xA5, flash model WIP=0 immediately:
  - Exact MOSI byte stream 06 | 02 00 F1 23 A5 | 05; three CS envelopes.
  - o_done at cycle 144; o_error=0; o_status=0x00.
- Erase, addr=0x00F000, WIP=1 for 3 polls then 0:
  - Stream 06 | 20 00 F0 00 | 05 ×4.
  - o_status=0x00 at done; total latency 128 + 3×38 cycles.
- POLL_LIMIT=2, WIP stuck at 1 (status 0x03):
  - Exactly 3 poll transactions, then o_done with o_error=1 and o_status=0x03.
  - o_error stays 1 until the next start.
- i_start pulsed while busy with different addr/data:
  - Ignored; the original transfer completes unchanged.
- Reset asserted mid-CMD (during the 3rd byte):
  - Same cycle: CS=1, SCK=0, MOSI=0, busy=0.
  - After release, a new program runs normally.
- SPI mode check:
  - MOSI is stable throughout every SCK-high phase.
  - No SCK edges while CS is high.
  - The CS-high gap between transactions is exactly CS_GAP cycles.

Source files
------------

// File: rtl/spi_flash_program_engine.sv
// SPI master that issues write-enable, page-program or sector-erase to the
// ROM flash and then polls the status register until the write completes.
module spi_flash_program_engine #(
    parameter int CS_GAP     = 4,
    parameter int POLL_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_erase,
    input  logic [23:0] i_addr,
    input  logic [7:0]  i_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [7:0]  o_status,
    output logic        o_SPI_CLK,
    output logic        o_SPI_MOSI,
    output logic        o_SPI_CS,
    input  logic        i_SPI_MISO
);

    typedef enum logic [2:0] {
        IDLE,
        WREN,
        GAP1,
        CMD,
        GAP2,
        POLL,
        GAP3,
        DONE
    } state_t;

    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
    localparam logic [15:0] POLL_MAX  = 16'(POLL_LIMIT);
    localparam logic [7:0]  OP_WREN   = 8'h06;
    localparam logic [7:0]  OP_PROG   = 8'h02;
    localparam logic [7:0]  OP_ERASE  = 8'h20;
    localparam logic [7:0]  OP_RDSR   = 8'h05;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [15:0] xfer_last;
    logic [15:0] poll_cnt;

    logic        erase_q;
    logic [23:0] addr_q;
    logic [7:0]  data_q;

    logic [7:0]  rx;
    logic [7:0]  rx_final;
    logic        sample;

    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  status;

    logic        sck;
    logic        mosi;
    logic        cs;
    logic        sck_d;
    logic        mosi_d;
    logic        cs_d;

    logic        accept;
    logic        poll_inc;
    logic        set_error;
    logic        in_xfer;
    logic        in_bits;
    logic [39:0] frame;
    logic [6:0]  cnt_m1;
    logic [5:0]  bit_idx;

    // Each CS-low state shifts out a left-aligned frame; xfer_last is its final cycle.
    always_comb begin
        in_xfer   = 1'b0;
        xfer_last = 16'd0;
        frame     = 40'h0;
        case (state)
            WREN: begin
                in_xfer   = 1'b1;
                xfer_last = 16'd17;
                frame     = {OP_WREN, 32'h0};
            end
            CMD: begin
                in_xfer   = 1'b1;
                xfer_last = erase_q ? 16'd65 : 16'd81;
                frame     = erase_q ? {OP_ERASE, addr_q, 8'h00}
                                    : {OP_PROG, addr_q, data_q};
            end
            POLL: begin
                in_xfer   = 1'b1;
                xfer_last = 16'd33;
                frame     = {OP_RDSR, 32'h0};
            end
            default: begin
                in_xfer   = 1'b0;
            end
        endcase
    end

    // Pins are registered, so the MISO edge that ends a visible phase B
    // falls on the odd count one past its decode; status bits start at 19.
    assign rx_final = {rx[6:0], i_SPI_MISO};
    assign sample   = (state == POLL) && cnt[0] && (cnt >= 16'd19);

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 16'd1;
        accept     = 1'b0;
        poll_inc   = 1'b0;
        set_error  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = 16'd0;
                if (i_start && !done) begin
                    accept     = 1'b1;
                    state_next = WREN;
                end
            end
            WREN: begin
                if (cnt == xfer_last) begin
                    state_next = GAP1;
                    cnt_next   = 16'd0;
                end
            end
            GAP1: begin
                if (cnt == GAP_LAST) begin
                    state_next = CMD;
                    cnt_next   = 16'd0;
                end
            end
            CMD: begin
                if (cnt == xfer_last) begin
                    state_next = GAP2;
                    cnt_next   = 16'd0;
                end
            end
            GAP2: begin
                if (cnt == GAP_LAST) begin
                    state_next = POLL;
                    cnt_next   = 16'd0;
                end
            end
            POLL: begin
                if (cnt == xfer_last) begin
                    cnt_next = 16'd0;
                    if (!rx_final[0]) begin
                        state_next = DONE;
                    end else if (poll_cnt < POLL_MAX) begin
                        poll_inc   = 1'b1;
                        state_next = GAP3;
                    end else begin
                        set_error  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            GAP3: begin
                if (cnt == GAP_LAST) begin
                    state_next = POLL;
                    cnt_next   = 16'd0;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    // Count 0 is CS setup, the last count is CS hold; bits sit in between.
    always_comb begin
        cnt_m1  = cnt[6:0] - 7'd1;
        bit_idx = cnt_m1[6:1];
        in_bits = in_xfer && (cnt != 16'd0) && (cnt != xfer_last);
        cs_d    = ~in_xfer;
        sck_d   = in_bits & cnt_m1[0];
        mosi_d  = in_bits & frame[6'd39 - bit_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            erase_q  <= 1'b0;
            addr_q   <= 24'h0;
            data_q   <= 8'h00;
            poll_cnt <= 16'd0;
            rx       <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            status   <= 8'h00;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs       <= 1'b1;
        end else begin
            sck  <= sck_d;
            mosi <= mosi_d;
            cs   <= cs_d;
            done <= (state == DONE);
            if (accept) begin
                erase_q  <= i_erase;
                addr_q   <= i_addr;
                data_q   <= i_data;
                poll_cnt <= 16'd0;
                busy     <= 1'b1;
                error    <= 1'b0;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
            if (poll_inc) begin
                poll_cnt <= poll_cnt + 16'd1;
            end
            if (set_error) begin
                error <= 1'b1;
            end
            if (sample) begin
                rx <= rx_final;
            end
            // Status becomes visible on the cycle CS actually rises.
            if ((state == DONE) || ((state == GAP3) && (cnt == 16'd0))) begin
                status <= rx;
            end
        end
    end

    assign o_busy     = busy;
    assign o_done     = done;
    assign o_error    = error;
    assign o_status   = status;
    assign o_SPI_CLK  = sck;
    assign o_SPI_MOSI = mosi;
    assign o_SPI_CS   = cs;

endmodule

// File: tb/tb_spi_flash_program_engine.sv
// Bench for spi_flash_program_engine: a behavioural flash slave decodes each
// CS envelope and the expected byte stream, timing and status are derived from the op.
module tb_spi_flash_program_engine;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        erase = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [7:0]  data = 8'h0;
    logic        sel = 1'b0;
    logic        miso = 1'b0;

    logic        busy_a, done_a, err_a, sck_a, mosi_a, cs_a;
    logic        busy_b, done_b, err_b, sck_b, mosi_b, cs_b;
    logic [7:0]  stat_a, stat_b;

    always #5 clk = ~clk;

    spi_flash_program_engine #(.CS_GAP(GAP)) dut_a (
        .clk(clk), .reset(rst_n), .i_start(start & ~sel), .i_erase(erase),
        .i_addr(addr), .i_data(data), .o_busy(busy_a), .o_done(done_a),
        .o_error(err_a), .o_status(stat_a), .o_SPI_CLK(sck_a),
        .o_SPI_MOSI(mosi_a), .o_SPI_CS(cs_a), .i_SPI_MISO(miso)
    );

    spi_flash_program_engine #(.CS_GAP(GAP), .POLL_LIMIT(2)) dut_b (
        .clk(clk), .reset(rst_n), .i_start(start & sel), .i_erase(erase),
        .i_addr(addr), .i_data(data), .o_busy(busy_b), .o_done(done_b),
        .o_error(err_b), .o_status(stat_b), .o_SPI_CLK(sck_b),
        .o_SPI_MOSI(mosi_b), .o_SPI_CS(cs_b), .i_SPI_MISO(miso)
    );

    wire       busy   = sel ? busy_b : busy_a;
    wire       done   = sel ? done_b : done_a;
    wire       error  = sel ? err_b  : err_a;
    wire [7:0] status = sel ? stat_b : stat_a;
    wire       sck    = sel ? sck_b  : sck_a;
    wire       mosi   = sel ? mosi_b : mosi_a;
    wire       cs     = sel ? cs_b   : cs_a;

    int checks = 0;
    int errors = 0;

    // Flash slave model state (written only by the model process).
    logic [7:0] st_tab [0:7];
    logic [7:0] stream [$];
    int         env_bits [$];
    int         env_done = 0;
    int         poll_idx = 0;
    int         bitcnt = 0;
    int         env_start = 0;
    int         viol_edge = 0;
    logic [7:0] shreg = 8'h0;
    logic [7:0] resp = 8'h0;
    logic       mosi_at_rise = 1'b0;
    logic       m_cs = 1'b1;
    logic       m_sck = 1'b0;

    // Clock-sampled monitor state.
    int   lo_runs [$];
    int   gaps [$];
    int   hi_run = 0;
    int   lo_run = 0;
    int   viol_clk = 0;
    logic prev_cs = 1'b1;

    // Per-op baselines written by the stimulus thread.
    int env_base = 0, stream_base = 0, bits_base = 0, lo_base = 0, gap_base = 0;
    int vbase_e = 0, vbase_c = 0, poll_base = 0;

    always @(cs or sck) begin
        int pi;
        if (cs === 1'b0 && m_cs === 1'b1) begin
            bitcnt    = 0;
            env_start = stream.size();
            pi = poll_idx - poll_base;
            if (pi > 7) pi = 7;
            if (pi < 0) pi = 0;
            resp = st_tab[pi];
            miso = 1'b0;
        end else if (cs === 1'b1 && m_cs === 1'b0) begin
            env_bits.push_back(bitcnt);
            env_done++;
            if (stream.size() > env_start && stream[env_start] == 8'h05) poll_idx++;
            miso = 1'b0;
        end
        if (sck === 1'b1 && m_sck === 1'b0) begin
            if (cs !== 1'b0) begin
                viol_edge++;
            end else begin
                shreg = {shreg[6:0], mosi};
                bitcnt++;
                if (bitcnt % 8 == 0) stream.push_back(shreg);
            end
            mosi_at_rise = mosi;
        end else if (sck === 1'b0 && m_sck === 1'b1) begin
            if (cs !== 1'b0) viol_edge++;
            else if (bitcnt >= 8 && bitcnt < 16) miso = resp[15 - bitcnt];
        end
        m_cs  = cs;
        m_sck = sck;
    end

    always @(negedge clk) begin
        if (cs === 1'b1 && sck === 1'b1) viol_clk++;
        if (sck === 1'b1 && mosi !== mosi_at_rise) viol_clk++;
        if (cs === 1'b1) begin
            if (prev_cs === 1'b0) begin
                lo_runs.push_back(lo_run);
                hi_run = 0;
            end
            hi_run++;
        end else if (cs === 1'b0) begin
            if (prev_cs === 1'b1) begin
                if (env_done > env_base) gaps.push_back(hi_run);
                lo_run = 0;
            end
            lo_run++;
        end
        prev_cs = cs;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic markBase();
        env_base    = env_done;
        stream_base = stream.size();
        bits_base   = env_bits.size();
        lo_base     = lo_runs.size();
        gap_base    = gaps.size();
        vbase_e     = viol_edge;
        vbase_c     = viol_clk;
        poll_base   = poll_idx;
    endtask

    // Leaves the caller one clock into the accepted op (cycle 1).
    task automatic pulseStart(input bit er, input logic [23:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        start = 1'b1; erase = er; addr = a; data = d;
        @(posedge clk); #1;
        start = 1'b0; erase = 1'($urandom); addr = 24'($urandom); data = 8'($urandom);
    endtask

    task automatic applyStimulus(input bit use_b, input bit er, input logic [23:0] a,
                                 input logic [7:0] d, input int wips, input bit stuck,
                                 input bit disturb, input bit rnd_status, input string tag);
        int         limit, npolls, exp_lat, n, cmd_bytes;
        logic [7:0] exp_q [$];
        int         exp_sz [$];
        logic [7:0] exp_st;
        logic [6:0] upper;

        sel = use_b;
        for (int i = 0; i < 8; i++) begin
            upper = rnd_status ? 7'($urandom) : 7'h0;
            if (stuck) st_tab[i] = 8'h03;
            else       st_tab[i] = {upper, (i < wips) ? 1'b1 : 1'b0};
        end
        limit     = use_b ? 2 : 65535;
        npolls    = stuck ? limit + 1 : wips + 1;
        exp_st    = st_tab[npolls - 1];
        cmd_bytes = er ? 4 : 5;
        exp_lat   = 1 + 18 + GAP + (16 * cmd_bytes + 2) + GAP + 34 + 1 + (npolls - 1) * (GAP + 34);

        exp_q.push_back(8'h06);
        exp_q.push_back(er ? 8'h20 : 8'h02);
        exp_q.push_back(a[23:16]);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        if (!er) exp_q.push_back(d);
        exp_sz.push_back(1);
        exp_sz.push_back(cmd_bytes);
        for (int p = 0; p < npolls; p++) begin
            exp_q.push_back(8'h05);
            exp_q.push_back(8'h00);
            exp_sz.push_back(2);
        end

        markBase();
        pulseStart(er, a, d);
        n = 1;
        checkOutput({tag, " busy_at_1"}, busy, 1);
        checkOutput({tag, " err_cleared"}, error, 0);
        while (done !== 1'b1 && n < 4000) begin
            if (disturb && n == 40) begin
                start = 1'b1; erase = ~er; addr = ~a; data = ~d;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        checkOutput({tag, " done_seen"}, done, 1);
        checkOutput({tag, " latency"}, n, exp_lat);
        checkOutput({tag, " busy_at_done"}, busy, 0);
        checkOutput({tag, " error"}, error, stuck);
        checkOutput({tag, " status"}, status, exp_st);

        // A start coinciding with done must be ignored.
        start = 1'b1; erase = ~er; addr = ~a; data = ~d;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput({tag, " start_on_done_ignored"}, busy, 0);
        checkOutput({tag, " done_one_cycle"}, done, 0);

        checkOutput({tag, " envelopes"}, env_bits.size() - bits_base, exp_sz.size());
        for (int i = 0; i < exp_sz.size(); i++) begin
            if (bits_base + i < env_bits.size())
                checkOutput($sformatf("%s env%0d_bits", tag, i), env_bits[bits_base + i], 8 * exp_sz[i]);
            if (lo_base + i < lo_runs.size())
                checkOutput($sformatf("%s env%0d_cs_low", tag, i), lo_runs[lo_base + i], 16 * exp_sz[i] + 2);
        end
        checkOutput({tag, " gap_count"}, gaps.size() - gap_base, exp_sz.size() - 1);
        for (int i = gap_base; i < gaps.size(); i++)
            checkOutput($sformatf("%s gap%0d", tag, i - gap_base), gaps[i], GAP);
        checkOutput({tag, " stream_len"}, stream.size() - stream_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (stream_base + i < stream.size())
                checkOutput($sformatf("%s byte%0d", tag, i), stream[stream_base + i], exp_q[i]);
        end
        checkOutput({tag, " spi_mode"}, (viol_edge - vbase_e) + (viol_clk - vbase_c), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) st_tab[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset cs", cs_a, 1);
        checkOutput("reset sck", sck_a, 0);
        checkOutput("reset mosi", mosi_a, 0);
        checkOutput("reset busy", busy_a, 0);
        checkOutput("reset done", done_a, 0);
        checkOutput("reset error", err_a, 0);
        checkOutput("reset status", stat_a, 8'h00);
        checkOutput("reset cs_b", cs_b, 1);
        rst_n = 1'b1;

        applyStimulus(0, 0, 24'h00F123, 8'hA5, 0, 0, 0, 0, "prog");
        applyStimulus(0, 1, 24'h00F000, 8'h00, 3, 0, 0, 0, "erase");

        applyStimulus(1, 0, 24'h001234, 8'h5A, 0, 1, 0, 0, "timeout");
        repeat (10) @(posedge clk);
        #1;
        checkOutput("timeout err_hold", error, 1);
        applyStimulus(1, 1, 24'h00A000, 8'h00, 1, 0, 0, 1, "after_timeout");

        applyStimulus(0, 0, 24'h3C0F11, 8'h96, 1, 0, 1, 1, "disturb");

        // Abort during the third CMD byte.
        sel = 1'b0;
        markBase();
        pulseStart(0, 24'h123456, 8'h3C);
        n = 1;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort cs_low_before", cs, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort cs", cs, 1);
        checkOutput("abort sck", sck, 0);
        checkOutput("abort mosi", mosi, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("abort status", status, 8'h00);
        applyStimulus(0, 0, 24'h0ABCDE, 8'h42, 0, 0, 0, 0, "post_abort");

        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1'($urandom), 24'($urandom), 8'($urandom),
                          $urandom_range(0, 3), 0, 1'($urandom), 1, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
